// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment predicate used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_t;

  // Reserved size 2'b10 behaves as a word, so anything not byte/half needs
  // both low address bits clear.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      LS_BYTE: mis = 1'b0;
      LS_HALF: mis = addr_lo[0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte enables and data replication, plus
// load lane extraction with sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  lst,
  input  logic [1:0]  addr_lo,
  input  logic        lu,
  input  logic [31:0] wdata_raw,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata_raw;
    case (lst)
      LS_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata_raw[7:0]}};
      end
      LS_HALF: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata_raw[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata_raw;
      end
    endcase
  end

  always_comb begin
    byte_sel = rdata_raw[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata_raw[7:0];
      2'd1: byte_sel = rdata_raw[15:8];
      2'd2: byte_sel = rdata_raw[23:16];
      2'd3: byte_sel = rdata_raw[31:24];
      default: byte_sel = rdata_raw[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
  end

  always_comb begin
    rdata_ext = rdata_raw;
    case (lst)
      LS_BYTE: rdata_ext = {{24{~lu & byte_sel[7]}}, byte_sel};
      LS_HALF: rdata_ext = {{16{~lu & half_sel[15]}}, half_sel};
      default: rdata_ext = rdata_raw;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store unit between execute and data memory: req/gnt/rvalid handshake,
// registered completion pulse. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu_dmem_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        lst,
  input  logic              lu,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              lsu_busy,
  output logic              lsu_done,
  output logic [31:0]       rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              lsu_misaligned,
`endif
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata
);

  // Handshake: dm_req is held with stable addr/we/be/wdata until the cycle
  // dm_gnt is sampled high; dm_rvalid is honoured only in WAIT, dm_gnt only
  // in REQ. lsu_done is a registered one-cycle pulse after the final beat.

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lst_q, lst_d;
  logic              lu_q, lu_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic              trap;
  logic [3:0]        be;
  logic [31:0]       wdata_lane;
  logic [31:0]       rdata_ext;

  lsu_align u_align (
    .lst        (lst_q),
    .addr_lo    (addr_q[1:0]),
    .lu         (lu_q),
    .wdata_raw  (wdata_q),
    .rdata_raw  (dm_rdata),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  assign accept = start & (mem_read | mem_write);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign trap           = is_misaligned(lst, addr[1:0]);
  assign lsu_misaligned = mis_q;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lst_d   = lst_q;
    lu_d    = lu_q;
    wdata_d = wdata_q;
    write_d = write_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (trap) begin
            // Completes in place: no request, registers and rdata untouched.
            done_d = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_d  = 1'b1;
`endif
          end else begin
            addr_d  = addr;
            lst_d   = lst;
            lu_d    = lu;
            wdata_d = wdata;
            write_d = ~mem_read;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dm_gnt) begin
          if (write_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dm_rvalid) begin
          rdata_d = rdata_ext;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lst_q   <= 2'b00;
      lu_q    <= 1'b0;
      wdata_q <= 32'h0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lst_q   <= lst_d;
      lu_q    <= lu_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end
`endif

  // Memory-side fields are masked in IDLE so the bus reads all-zero at rest.
  assign lsu_busy = (state_q != ST_IDLE);
  assign lsu_done = done_q;
  assign rdata    = rdata_q;
  assign dm_req   = (state_q == ST_REQ);
  assign dm_we    = lsu_busy & write_q;
  assign dm_be    = lsu_busy ? be : 4'b0000;
  assign dm_addr  = lsu_busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign dm_wdata = (lsu_busy & write_q) ? wdata_lane : 32'h0;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed bench for lsu_dmem_if: stores, loads, busy/back-to-back starts,
// mid-access reset; misaligned trap steps when LSU_MISALIGN_TRAP_EN is set.
module tb_lsu_dmem_if;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  lst;
  logic        lu;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic [31:0] rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        lsu_misaligned;
`endif
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int xfer_base;

  lsu_dmem_if #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .lst            (lst),
    .lu             (lu),
    .addr           (addr),
    .wdata          (wdata),
    .lsu_busy       (lsu_busy),
    .lsu_done       (lsu_done),
    .rdata          (rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .lsu_misaligned (lsu_misaligned),
`endif
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_be          (dm_be),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_gnt         (dm_gnt),
    .dm_rvalid      (dm_rvalid),
    .dm_rdata       (dm_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted memory transactions (req and gnt in the same cycle)
  always @(posedge clk) begin
    if (dm_req && dm_gnt) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: one-cycle start pulse; request fields are scrambled afterwards
  // so later checks prove the DUT used its registered copy.
  task automatic drive_start(input logic rd, input logic wr, input logic [1:0] size,
                             input logic uns, input logic [31:0] a, input logic [31:0] d);
    start     = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    lst       = size;
    lu        = uns;
    addr      = a;
    wdata     = d;
    tick();
    start     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    lst       = 2'(($urandom_range(0, 3)));
    lu        = 1'($urandom_range(0, 1));
    addr      = $urandom;
    wdata     = $urandom;
  endtask

  // Full load: grant immediately, rvalid rv_gap cycles after the grant cycle.
  task automatic load_txn(input string tag, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] mem_word,
                          input int rv_gap, input logic [3:0] exp_be,
                          input logic [31:0] exp_rdata);
    drive_start(1'b1, 1'b0, size, uns, a, 32'h0);
    chk({tag, "_req"}, 32'(dm_req), 32'h1);
    chk({tag, "_we"}, 32'(dm_we), 32'h0);
    chk({tag, "_be"}, 32'(dm_be), 32'(exp_be));
    chk({tag, "_addr"}, dm_addr, {a[31:2], 2'b00});
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk({tag, "_req_drop"}, 32'(dm_req), 32'h0);
    for (int i = 1; i < rv_gap; i++) tick();
    chk({tag, "_no_early_done"}, 32'(lsu_done), 32'h0);
    dm_rvalid = 1'b1;
    dm_rdata  = mem_word;
    tick();
    dm_rvalid = 1'b0;
    dm_rdata  = $urandom;
    chk({tag, "_done"}, 32'(lsu_done), 32'h1);
    chk({tag, "_rdata"}, rdata, exp_rdata);
    tick();
    chk({tag, "_done_pulse"}, 32'(lsu_done), 32'h0);
    chk({tag, "_rdata_hold"}, rdata, exp_rdata);
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    lst       = 2'b00;
    lu        = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = 32'h0;
    #1;

    // Reset state
    chk("rst_req", 32'(dm_req), 32'h0);
    chk("rst_busy", 32'(lsu_busy), 32'h0);
    chk("rst_done", 32'(lsu_done), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_be", 32'(dm_be), 32'h0);
    chk("rst_addr", dm_addr, 32'h0);
    chk("rst_wdata", dm_wdata, 32'h0);
    chk("rst_we", 32'(dm_we), 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // sb 0xAB @0x1003, grant withheld two cycles
    drive_start(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB);
    chk("sb_req", 32'(dm_req), 32'h1);
    chk("sb_busy", 32'(lsu_busy), 32'h1);
    chk("sb_we", 32'(dm_we), 32'h1);
    chk("sb_be", 32'(dm_be), 32'h8);
    chk("sb_wdata", dm_wdata, 32'hABAB_ABAB);
    chk("sb_addr", dm_addr, 32'h0000_1000);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sb_stall_req", 32'(dm_req), 32'h1);
      chk("sb_stall_be", 32'(dm_be), 32'h8);
      chk("sb_stall_wdata", dm_wdata, 32'hABAB_ABAB);
      chk("sb_stall_addr", dm_addr, 32'h0000_1000);
      chk("sb_stall_done", 32'(lsu_done), 32'h0);
    end
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("sb_done", 32'(lsu_done), 32'h1);
    chk("sb_busy_clr", 32'(lsu_busy), 32'h0);
    chk("sb_req_clr", 32'(dm_req), 32'h0);
    tick();
    chk("sb_done_pulse", 32'(lsu_done), 32'h0);

    // sh @0x1006 and reserved-size store @0x1008
    drive_start(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_1006, 32'h1234_BEEF);
    chk("sh_be", 32'(dm_be), 32'hC);
    chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("sh_done", 32'(lsu_done), 32'h1);
    drive_start(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_1008, 32'hCAFE_F00D);
    chk("srsv_be", 32'(dm_be), 32'hF);
    chk("srsv_wdata", dm_wdata, 32'hCAFE_F00D);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("srsv_done", 32'(lsu_done), 32'h1);
    tick();

    // Loads: lb, lbu, lh, lhu, lw with late rvalid
    load_txn("lb", 2'b00, 1'b0, 32'h0000_2002, 32'h0080_0000, 1, 4'b0100, 32'hFFFF_FF80);
    load_txn("lbu", 2'b00, 1'b1, 32'h0000_2002, 32'h0080_0000, 1, 4'b0100, 32'h0000_0080);
    load_txn("lh", 2'b01, 1'b0, 32'h0000_2002, 32'h8001_0000, 1, 4'b1100, 32'hFFFF_8001);
    load_txn("lhu", 2'b01, 1'b1, 32'h0000_2000, 32'h0000_9234, 2, 4'b0011, 32'h0000_9234);
    load_txn("lw", 2'b11, 1'b0, 32'h0000_2000, 32'hDEAD_BEEF, 3, 4'b1111, 32'hDEAD_BEEF);

    // Stray grant in IDLE and start with no operation
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("idle_gnt_busy", 32'(lsu_busy), 32'h0);
    chk("idle_gnt_done", 32'(lsu_done), 32'h0);
    drive_start(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_4000, 32'h0);
    chk("nop_start_busy", 32'(lsu_busy), 32'h0);
    chk("nop_start_req", 32'(dm_req), 32'h0);

    // Read and write together: load wins
    load_txn("rdwr_pre", 2'b11, 1'b0, 32'h0000_2004, 32'h0BAD_F00D, 1, 4'b1111, 32'h0BAD_F00D);
    drive_start(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_2008, 32'h7777_7777);
    chk("rdwr_we", 32'(dm_we), 32'h0);
    chk("rdwr_wdata", dm_wdata, 32'h0);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("rdwr_wait_busy", 32'(lsu_busy), 32'h1);
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h1357_9BDF;
    tick();
    dm_rvalid = 1'b0;
    chk("rdwr_done", 32'(lsu_done), 32'h1);
    chk("rdwr_rdata", rdata, 32'h1357_9BDF);
    tick();

    // start while busy, then back-to-back start in the done cycle
    xfer_base = xfer_cnt;
    drive_start(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    drive_start(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_0099);
    chk("busy_start_req", 32'(dm_req), 32'h0);
    chk("busy_start_busy", 32'(lsu_busy), 32'h1);
    chk("busy_start_addr", dm_addr, 32'h0000_3000);
    chk("busy_start_we", 32'(dm_we), 32'h0);
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h1122_3344;
    tick();
    dm_rvalid = 1'b0;
    chk("b2b_done1", 32'(lsu_done), 32'h1);
    chk("b2b_rdata1", rdata, 32'h1122_3344);
    drive_start(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_3004, 32'h5566_7788);
    chk("b2b_req2", 32'(dm_req), 32'h1);
    chk("b2b_we2", 32'(dm_we), 32'h1);
    chk("b2b_addr2", dm_addr, 32'h0000_3004);
    chk("b2b_wdata2", dm_wdata, 32'h5566_7788);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("b2b_done2", 32'(lsu_done), 32'h1);
    tick();
    chk("b2b_xfers", 32'(xfer_cnt - xfer_base), 32'd2);
    chk("b2b_idle", 32'(lsu_busy), 32'h0);

    // Asynchronous reset while waiting for read data
    drive_start(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_6000, 32'h0);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("rstw_in_wait", 32'(lsu_busy), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rstw_req", 32'(dm_req), 32'h0);
    chk("rstw_busy", 32'(lsu_busy), 32'h0);
    chk("rstw_done", 32'(lsu_done), 32'h0);
    chk("rstw_rdata", rdata, 32'h0);
    chk("rstw_be", 32'(dm_be), 32'h0);
    tick();
    rstn = 1'b1;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'hFEED_FACE;
    tick();
    dm_rvalid = 1'b0;
    chk("rstw_stray_done", 32'(lsu_done), 32'h0);
    chk("rstw_stray_rdata", rdata, 32'h0);
    chk("rstw_stray_busy", 32'(lsu_busy), 32'h0);
    tick();
    chk("rstw_stray_done2", 32'(lsu_done), 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned word load traps without touching memory
    xfer_base = xfer_cnt;
    drive_start(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_2001, 32'h0);
    chk("mis_req", 32'(dm_req), 32'h0);
    chk("mis_done", 32'(lsu_done), 32'h1);
    chk("mis_flag", 32'(lsu_misaligned), 32'h1);
    chk("mis_busy", 32'(lsu_busy), 32'h0);
    chk("mis_rdata", rdata, 32'h0);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("mis_done_pulse", 32'(lsu_done), 32'h0);
    chk("mis_flag_pulse", 32'(lsu_misaligned), 32'h0);
    chk("mis_xfers", 32'(xfer_cnt - xfer_base), 32'd0);
    load_txn("mis_ok_lh", 2'b01, 1'b0, 32'h0000_2002, 32'h7FFF_0000, 1, 4'b1100, 32'h0000_7FFF);
`else
    // Without the trap the low bits are ignored and the word access proceeds
    load_txn("lw_odd", 2'b11, 1'b0, 32'h0000_2001, 32'hA5A5_5A5A, 1, 4'b1111, 32'hA5A5_5A5A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
